// File: rtl/srs_angle_sched.sv
// srs_angle_sched: runs one SRS slot as (symbol x port) engine jobs and tags the returned sample stream.
// Optional build macro SRS_SCHED_TIMEOUT_EN adds a 16-bit RUN watchdog.
module srs_angle_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  symb_num,
  input  logic [1:0]  n_port,
  input  logic [3:0]  n_cs,
  input  logic [3:0]  n_cs_max,
  input  logic [10:0] m_sc,
  output logic        busy,
  output logic        done,
  output logic        err_cfg,
  output logic        eng_start,
  output logic [1:0]  eng_symb_index,
  output logic [3:0]  eng_alpha_p,
  input  logic        eng_phi_en,
  input  logic [11:0] eng_phi_val,
  output logic        phi_en,
  output logic [11:0] phi_val,
  output logic [1:0]  phi_port,
  output logic [1:0]  phi_symb
);

  typedef enum logic [2:0] {IDLE, ISSUE, RUN, NEXT, FIN} state_t;

  state_t      state, state_nxt;

  logic        accept, take, last_job, sample_last, timeout;
  logic [1:0]  last_symb, last_port, port_shift;
  logic [3:0]  cs_base, cs_max;
  logic [10:0] sc_last, samp_cnt;
  logic        sc_zero;
  logic [1:0]  port_cnt, symb_cnt;
  logic [3:0]  alpha, alpha_step, alpha_adv;
  logic [4:0]  alpha_sum, alpha_wrap;

  logic [1:0]  dec_last_symb, dec_last_port, dec_shift;
  logic [3:0]  dec_cs;
  logic        dec_err;

  // Raw config decode; only consumed on the accept cycle.
  always_comb begin
    dec_last_symb = 2'd0;
    case (symb_num)
      2'b01:   dec_last_symb = 2'd1;
      2'b11:   dec_last_symb = 2'd3;
      default: dec_last_symb = 2'd0;
    endcase
    dec_last_port = n_port[1] ? 2'd3 : {1'b0, n_port[0]};
    dec_shift     = n_port[1] ? 2'd2 : {1'b0, n_port[0]};
    dec_cs        = (n_cs >= n_cs_max) ? (n_cs - n_cs_max) : n_cs;
    dec_err       = (symb_num == 2'b10) || (n_cs >= n_cs_max) || (m_sc == '0);
  end

  // Per-port alpha advances by n_cs_max/nport with a single wrap subtract,
  // valid because both operands are already below n_cs_max.
  always_comb begin
    alpha_step = cs_max >> port_shift;
    alpha_sum  = {1'b0, alpha} + {1'b0, alpha_step};
    alpha_wrap = alpha_sum - {1'b0, cs_max};
    alpha_adv  = (alpha_sum >= {1'b0, cs_max}) ? alpha_wrap[3:0] : alpha_sum[3:0];
  end

  assign accept      = (state == IDLE) && start && !abort;
  assign take        = (state == RUN) && eng_phi_en && !abort;
  assign last_job    = (port_cnt == last_port) && (symb_cnt == last_symb);
  assign sample_last = (samp_cnt == sc_last);

`ifdef SRS_SCHED_TIMEOUT_EN
  logic [15:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != RUN || eng_phi_en) wd_cnt <= '0;
    else                                   wd_cnt <= wd_cnt + 16'd1;
  end

  assign timeout = (state == RUN) && !eng_phi_en && (wd_cnt == '1);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    eng_start = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (sc_zero) state_nxt = FIN;
        else begin
          eng_start = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (eng_phi_en && sample_last) state_nxt = NEXT;
        else if (timeout)              state_nxt = FIN;
      end
      NEXT:    state_nxt = last_job ? FIN : ISSUE;
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      err_cfg    <= 1'b0;
      last_symb  <= '0;
      last_port  <= '0;
      port_shift <= '0;
      cs_base    <= '0;
      cs_max     <= '0;
      sc_last    <= '0;
      sc_zero    <= 1'b0;
      port_cnt   <= '0;
      symb_cnt   <= '0;
      alpha      <= '0;
      samp_cnt   <= '0;
      phi_en     <= 1'b0;
      phi_val    <= '0;
      phi_port   <= '0;
      phi_symb   <= '0;
    end else begin
      state  <= state_nxt;
      phi_en <= take;
      if (take) begin
        phi_val  <= eng_phi_val;
        phi_port <= port_cnt;
        phi_symb <= symb_cnt;
      end

      if (accept) begin
        err_cfg    <= dec_err;
        last_symb  <= dec_last_symb;
        last_port  <= dec_last_port;
        port_shift <= dec_shift;
        cs_base    <= dec_cs;
        cs_max     <= n_cs_max;
        sc_last    <= m_sc - 11'd1;
        sc_zero    <= (m_sc == '0);
        port_cnt   <= '0;
        symb_cnt   <= '0;
        alpha      <= dec_cs;
      end else if (timeout) begin
        err_cfg <= 1'b1;
      end

      if (state == ISSUE) samp_cnt <= '0;
      else if (take)      samp_cnt <= samp_cnt + 11'd1;

      if (state == NEXT && !last_job) begin
        if (port_cnt == last_port) begin
          port_cnt <= '0;
          symb_cnt <= symb_cnt + 2'd1;
          alpha    <= cs_base;
        end else begin
          port_cnt <= port_cnt + 2'd1;
          alpha    <= alpha_adv;
        end
      end
    end
  end

  assign eng_symb_index = symb_cnt;
  assign eng_alpha_p    = alpha;

endmodule

// File: doc/srs_angle_sched.md
SRS_ANGLE_SCHED -- requirements
Module: srs_angle_sched

Interface
REQ-001 SHALL provide ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL provide: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL provide: start  in  1  one-cycle request to run one SRS slot; abort  in  1  one-cycle cancel.
REQ-004 SHALL provide: symb_num  in  2  00=1, 01=2, 10=reserved, 11=4 symbols; n_port  in  2  00=1, 01=2, 1x=4 ports.
REQ-005 SHALL provide: n_cs  in  4  base cyclic shift; n_cs_max  in  4  8 or 12; m_sc  in  11  samples per symbol.
REQ-006 SHALL provide: busy  out  1; done  out  1  one-cycle pulse; err_cfg  out  1  sticky until next accepted start.
REQ-007 SHALL provide engine side: eng_start  out  1  one-cycle pulse; eng_symb_index  out  2; eng_alpha_p  out  4; eng_phi_en  in  1; eng_phi_val  in  12.
REQ-008 SHALL provide: phi_en  out  1; phi_val  out  12; phi_port  out  2; phi_symb  out  2  tagged sample stream.

Function
REQ-009 SHALL implement states IDLE, ISSUE, RUN, NEXT, FIN; all config inputs SHALL be latched on the cycle start is accepted in IDLE.
REQ-010 start SHALL be accepted only in IDLE; start while busy SHALL be ignored with no side effects.
REQ-011 Accepted start SHALL move to ISSUE; eng_start SHALL pulse for exactly one cycle in ISSUE (1 cycle after start), then the state SHALL move to RUN.
REQ-012 Job order SHALL be symbol outer (0..nsym-1), port inner (0..nport-1); total jobs = nsym*nport.
REQ-013 eng_symb_index SHALL equal the current symbol counter; eng_alpha_p SHALL equal (n_cs + p*(n_cs_max/nport)) mod n_cs_max, p = current port, computed with shift/add and held stable from ISSUE through RUN.
REQ-014 In RUN a 11-bit sample counter SHALL increment per eng_phi_en; the sample with counter == m_sc-1 SHALL move the state to NEXT.
REQ-015 phi_en/phi_val SHALL be eng_phi_en/eng_phi_val registered by one cycle, with phi_port/phi_symb being the current job indices; eng_phi_en outside RUN SHALL be dropped (phi_en stays 0).
REQ-016 NEXT SHALL advance port, wrapping to 0 and incrementing symbol; if the finished job was the last, go to FIN, else ISSUE.
REQ-017 FIN SHALL pulse done for one cycle and return to IDLE; busy SHALL be 1 in every state except IDLE.
REQ-018 symb_num=10 SHALL run as 1 symbol and set err_cfg; n_cs >= n_cs_max SHALL be reduced mod n_cs_max and set err_cfg.
REQ-019 m_sc=0 SHALL issue no eng_start, set err_cfg, and go directly to FIN (done 2 cycles after start).
REQ-020 abort SHALL return the block to IDLE on the next edge from any state with no done pulse; abort simultaneous with start in IDLE SHALL win (start dropped).

Reset
REQ-021 On rst: state=IDLE; busy, done, eng_start, phi_en, err_cfg = 0; eng_symb_index, eng_alpha_p, phi_val, phi_port, phi_symb, all counters = 0.
REQ-022 rst asserted mid-job SHALL abandon the job without done; the first start after rst deassertion SHALL be accepted normally.

Configuration
REQ-023 Macro SRS_SCHED_TIMEOUT_EN: when defined, a 16-bit watchdog SHALL count cycles in RUN since the last eng_phi_en; reaching 65535 SHALL set err_cfg and go to FIN; when undefined, there SHALL be no watchdog and RUN SHALL wait indefinitely.

Verification
REQ-024 symb_num=11, n_port=1x, n_cs=1, n_cs_max=8, m_sc=48 -> 16 eng_start pulses; alpha sequence 1,3,5,7 per symbol; 768 phi_en; one done.
REQ-025 n_port=01, n_cs=0, n_cs_max=12, symb_num=00, m_sc=24 -> alpha 0 then 6; phi_port 0 for 24 samples then 1 for 24.
REQ-026 start repeated while busy -> ignored; abort during RUN of job 2 -> IDLE next cycle, no done, busy=0.
REQ-027 m_sc=0 -> no eng_start, err_cfg=1, done 2 cycles after start; symb_num=10 -> 1 symbol run, err_cfg=1.
REQ-028 With SRS_SCHED_TIMEOUT_EN, engine stalls after eng_start -> done and err_cfg=1 after 65535 idle cycles; without the macro -> busy stays 1.
